// File: rtl/array_pkg.sv
// Shared types and helpers for the flattened-array serializer and its flattening stage.
package array_pkg;

    typedef enum logic {
        ORDER_COL_FAST,
        ORDER_ROW_FAST
    } serial_order_e;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bit offset of element (row, col) in a column-major flattened array.
    function automatic int unsigned elem_offset(input int unsigned row, input int unsigned col,
                                                input int unsigned rows,
                                                input int unsigned bit_width);
        return (col * rows + row) * bit_width;
    endfunction

endpackage

// File: rtl/row_col_counter.sv
// Row/column position counter; the fast index wraps and carries into the slow one.
module row_col_counter
    import array_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned ROW_MAJOR = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    output logic [idx_width(ROWS)-1:0] row,
    output logic [idx_width(COLS)-1:0] col,
    output logic                       last
);

    localparam int unsigned ROW_W = idx_width(ROWS);
    localparam int unsigned COL_W = idx_width(COLS);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam serial_order_e ORDER = (ROW_MAJOR != 0) ? ORDER_COL_FAST : ORDER_ROW_FAST;

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en && !last) begin
            if (ORDER == ORDER_COL_FAST) begin
                if (col_q == COL_MAX) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    col_d = col_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/flat_array_serializer.sv
// Captures one flattened ROWS x COLS array and replays it element by element
// with row/col tags over a valid/ready stream.
module flat_array_serializer
    import array_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 4,
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned ROW_MAJOR = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ROWS*COLS*BIT_WIDTH-1:0]    in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [BIT_WIDTH-1:0]              out_data,
    output logic [idx_width(ROWS)-1:0]        out_row,
    output logic [idx_width(COLS)-1:0]        out_col,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int unsigned BUF_W = ROWS * COLS * BIT_WIDTH;
    localparam int unsigned OFF_W = idx_width(BUF_W);

    state_e                      state_q, state_d;
    logic [BUF_W-1:0]            buf_q;
    logic [idx_width(ROWS)-1:0]  cnt_row;
    logic [idx_width(COLS)-1:0]  cnt_col;
    logic                        cnt_last;
    logic                        capture;
    logic                        beat_done;
    logic [OFF_W-1:0]            offset;

    assign capture   = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;
    // Sized to address every bit of the buffer, so the offset is never truncated.
    assign offset    = OFF_W'(elem_offset(32'(cnt_row), 32'(cnt_col), ROWS, BIT_WIDTH));

    row_col_counter #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .ROW_MAJOR (ROW_MAJOR)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (capture),
        .en   (beat_done),
        .row  (cnt_row),
        .col  (cnt_col),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                buf_q <= in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (capture) state_d = StSend;
            StSend: if (beat_done && cnt_last) state_d = capture ? StSend : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        unique case (state_q)
            StIdle: in_ready = !rst;
            StSend: begin
                out_valid = 1'b1;
                out_data  = buf_q[offset +: BIT_WIDTH];
                out_row   = cnt_row;
                out_col   = cnt_col;
                out_last  = cnt_last;
                // Accepting the final beat frees the buffer for a bubble-free reload.
                in_ready  = !rst && out_ready && cnt_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flat_array_serializer.sv
// Randomized and directed bench for flat_array_serializer against a queue-based frame model.
module tb_flat_array_serializer;

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic       rm_in_ready, rm_out_last, rm_out_valid;
    logic [3:0] rm_out_data;
    logic [0:0] rm_out_row;
    logic [1:0] rm_out_col;
    logic       cm_in_ready, cm_out_last, cm_out_valid;
    logic [3:0] cm_out_data;
    logic [0:0] cm_out_row;
    logic [1:0] cm_out_col;
    logic       one_in_ready, one_out_last, one_out_valid;
    logic [3:0] one_out_data;
    logic [0:0] one_out_row;
    logic [0:0] one_out_col;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    int n_tests = 0;
    int n_fail  = 0;

    flat_array_serializer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .ROW_MAJOR(1)) dut_rm (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rm_in_ready),
        .out_data(rm_out_data), .out_row(rm_out_row), .out_col(rm_out_col),
        .out_last(rm_out_last), .out_valid(rm_out_valid), .out_ready(out_ready)
    );

    flat_array_serializer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .ROW_MAJOR(0)) dut_cm (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(cm_in_ready),
        .out_data(cm_out_data), .out_row(cm_out_row), .out_col(cm_out_col),
        .out_last(cm_out_last), .out_valid(cm_out_valid), .out_ready(out_ready)
    );

    flat_array_serializer #(.BIT_WIDTH(4), .ROWS(1), .COLS(1), .ROW_MAJOR(1)) dut_one (
        .clk(clk), .rst(rst), .in_data(in_data[3:0]), .in_valid(in_valid),
        .in_ready(one_in_ready), .out_data(one_out_data), .out_row(one_out_row),
        .out_col(one_out_col), .out_last(one_out_last), .out_valid(one_out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int sz);
        return !rst && (sz == 0 || (sz == 1 && out_ready));
    endfunction

    // Enumerate the frame's beats directly from the traversal order.
    task automatic push_frame(input int k, input logic [23:0] d, input int rows, input int cols,
                              input bit row_major);
        beat_t b;
        int r;
        int c;
        for (int i = 0; i < rows * cols; i++) begin
            r = row_major ? i / cols : i % rows;
            c = row_major ? i % cols : i / rows;
            b.data = int'(d[(c * rows + r) * 4 +: 4]);
            b.row  = r;
            b.col  = c;
            b.last = (i == rows * cols - 1);
            case (k)
                0: q0.push_back(b);
                1: q1.push_back(b);
                default: q2.push_back(b);
            endcase
        end
    endtask

    task automatic update_models();
        bit a;
        bit b;
        bit c;
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            a = exp_ready(q0.size());
            b = exp_ready(q1.size());
            c = exp_ready(q2.size());
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (q2.size() > 0 && out_ready) void'(q2.pop_front());
            if (in_valid && a) push_frame(0, in_data, 2, 3, 1'b1);
            if (in_valid && b) push_frame(1, in_data, 2, 3, 1'b0);
            if (in_valid && c) push_frame(2, in_data, 1, 1, 1'b1);
        end
    endtask

    task automatic check_dut(input int k, input string name, input logic irdy, input logic ovld,
                             input int od, input int orow, input int ocol, input logic olast);
        beat_t head;
        int sz;
        head = '{data: 0, row: 0, col: 0, last: 1'b0};
        case (k)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz > 0) begin
            case (k)
                0: head = q0[0];
                1: head = q1[0];
                default: head = q2[0];
            endcase
        end
        check_eq({name, ".in_ready"}, 32'(irdy), 32'(exp_ready(sz)));
        check_eq({name, ".out_valid"}, 32'(ovld), (sz > 0) ? 1 : 0);
        check_eq({name, ".out_last"}, 32'(olast), 32'(head.last));
        if (sz > 0) begin
            check_eq({name, ".out_data"}, od, head.data);
            check_eq({name, ".out_row"}, orow, head.row);
            check_eq({name, ".out_col"}, ocol, head.col);
        end
    endtask

    task automatic cycle(input logic r, input logic iv, input logic orr, input logic [23:0] d);
        rst       = r;
        in_valid  = iv;
        out_ready = orr;
        in_data   = d;
        #1;
        check_dut(0, "rm", rm_in_ready, rm_out_valid, 32'(rm_out_data), 32'(rm_out_row),
                  32'(rm_out_col), rm_out_last);
        check_dut(1, "cm", cm_in_ready, cm_out_valid, 32'(cm_out_data), 32'(cm_out_row),
                  32'(cm_out_col), cm_out_last);
        check_dut(2, "one", one_in_ready, one_out_valid, 32'(one_out_data), 32'(one_out_row),
                  32'(one_out_col), one_out_last);
        @(posedge clk);
        update_models();
        #1;
    endtask

    function automatic logic [23:0] pattern(input int base);
        logic [23:0] v;
        v = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                v[(c * 2 + r) * 4 +: 4] = 4'(base + r * 3 + c);
            end
        end
        return v;
    endfunction

    initial begin
        bit stall_pat[4];
        stall_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with in_valid offered while in reset.
        cycle(1'b1, 1'b1, 1'b1, pattern(0));
        cycle(1'b1, 1'b0, 1'b1, '0);

        // Both traversal orders, free-flowing output.
        cycle(1'b0, 1'b1, 1'b1, pattern(0));
        repeat (7) cycle(1'b0, 1'b0, 1'b1, '0);

        // Stalls with out_ready 1,0,0,1.
        cycle(1'b0, 1'b1, 1'b1, pattern(0));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, stall_pat[i % 4], '0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, '0);

        // Back-to-back arrays with in_valid held high.
        cycle(1'b0, 1'b1, 1'b1, pattern(0));
        repeat (11) cycle(1'b0, 1'b1, 1'b1, pattern(6));
        repeat (8) cycle(1'b0, 1'b0, 1'b1, '0);

        // Reset in the middle of a frame, then a fresh frame.
        cycle(1'b0, 1'b1, 1'b1, pattern(0));
        repeat (3) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b1, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b1, pattern(6));
        repeat (7) cycle(1'b0, 1'b0, 1'b1, '0);

        // Single-element array carrying 0xA.
        cycle(1'b0, 1'b1, 1'b1, 24'h00000A);
        repeat (7) cycle(1'b0, 1'b0, 1'b1, '0);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) < 7), 24'($urandom));
        end
        repeat (8) cycle(1'b0, 1'b0, 1'b1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
